// File: rtl/mem_access_arbiter.sv
// Two-requester arbiter that serialises every access to the 8x8 memory array.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise A wins ties.
module mem_access_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_op,
  input  logic [ADDR_W-1:0] a_adr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  input  logic              b_req,
  input  logic              b_op,
  input  logic [ADDR_W-1:0] b_adr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              rsp_valid_a,
  output logic              rsp_valid_b,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_op,
  output logic              mem_select,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t             r_state;
  logic               r_owner;
  logic               r_rsp_valid_a;
  logic               r_rsp_valid_b;
  logic [DATA_W-1:0]  r_rsp_data;
  logic [ADDR_W-1:0]  r_mem_adr;
  logic               r_mem_op;
  logic               r_mem_select;
  logic [DATA_W-1:0]  r_mem_wdata;

  logic w_idle;
  logic w_grant_a;
  logic w_grant_b;

  // Accepts are suppressed during reset so a requester never sees a lost grant.
  assign w_idle = (r_state == S_IDLE) && !rst;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_rr_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_b <= 1'b0;
    end else if (w_grant_a || w_grant_b) begin
      r_rr_b <= w_grant_a;
    end
  end

  assign w_grant_b = w_idle && b_req && (!a_req || r_rr_b);
`else
  assign w_grant_b = w_idle && b_req && !a_req;
`endif

  assign w_grant_a = w_idle && a_req && !w_grant_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_owner       <= 1'b0;
      r_rsp_valid_a <= 1'b0;
      r_rsp_valid_b <= 1'b0;
      r_rsp_data    <= '0;
      r_mem_adr     <= '0;
      r_mem_op      <= 1'b0;
      r_mem_select  <= 1'b0;
      r_mem_wdata   <= '0;
    end else begin
      r_rsp_valid_a <= 1'b0;
      r_rsp_valid_b <= 1'b0;
      r_mem_select  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_a || w_grant_b) begin
            r_owner      <= w_grant_b;
            r_mem_op     <= w_grant_b ? b_op    : a_op;
            r_mem_adr    <= w_grant_b ? b_adr   : a_adr;
            r_mem_wdata  <= w_grant_b ? b_wdata : a_wdata;
            r_mem_select <= 1'b1;
            r_state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_mem_op) begin
            r_state <= S_IDLE;
          end else begin
            r_rsp_data    <= mem_rdata;
            r_rsp_valid_a <= !r_owner;
            r_rsp_valid_b <= r_owner;
            r_state       <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign a_ready     = w_grant_a;
  assign b_ready     = w_grant_b;
  assign rsp_valid_a = r_rsp_valid_a;
  assign rsp_valid_b = r_rsp_valid_b;
  assign rsp_data    = r_rsp_data;
  assign mem_adr     = r_mem_adr;
  assign mem_op      = r_mem_op;
  assign mem_select  = r_mem_select;
  assign mem_wdata   = r_mem_wdata;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter: a transaction-level model predicts
// grants, array accesses and responses; a separate monitor checks them.
module tb_mem_access_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 1'b0, a_op = 1'b0, b_req = 1'b0, b_op = 1'b0;
  logic [2:0] a_adr = '0, b_adr = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic       a_ready, b_ready, rsp_valid_a, rsp_valid_b;
  logic [7:0] rsp_data, mem_wdata, mem_rdata;
  logic [2:0] mem_adr;
  logic       mem_op, mem_select, busy;

  always #5 clk = ~clk;

  mem_access_arbiter #(.ADDR_W(3), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_op(a_op), .a_adr(a_adr), .a_wdata(a_wdata), .a_ready(a_ready),
    .b_req(b_req), .b_op(b_op), .b_adr(b_adr), .b_wdata(b_wdata), .b_ready(b_ready),
    .rsp_valid_a(rsp_valid_a), .rsp_valid_b(rsp_valid_b), .rsp_data(rsp_data),
    .mem_adr(mem_adr), .mem_op(mem_op), .mem_select(mem_select),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory array model driven by the DUT; preloaded with i*17 on reset.
  logic [7:0] arr [8];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) arr[i] <= 8'(i * 17);
    end else if (mem_select && mem_op) begin
      arr[mem_adr] <= mem_wdata;
    end
  end
  assign mem_rdata = arr[mem_adr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         b;
    bit         op;
    logic [2:0] adr;
    logic [7:0] wd;
    logic [7:0] rd;
    int         acc;
  } txn_t;

  txn_t acc_q[$];
  txn_t rsp_q[$];

  int errors = 0;
  int checks = 0;

  bit         pend[2];
  bit         auto_re[2];
  bit         p_op[2];
  logic [2:0] p_adr[2];
  logic [7:0] p_wd[2];
  logic [7:0] mdl_mem[8];
  bit         rr_b = 1'b0;
  int         free = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endfunction

  // Monitor: every array access and every response must match the model's queue.
  always @(negedge clk) begin
    txn_t t;
    if (mem_select === 1'b1) begin
      if (acc_q.size() == 0) begin
        chk("unexpected_select", 32'(mem_select), 32'(0));
      end else begin
        t = acc_q.pop_front();
        chk("mem_op", 32'(mem_op), 32'(t.op));
        chk("mem_adr", 32'(mem_adr), 32'(t.adr));
        chk("mem_wdata", 32'(mem_wdata), 32'(t.wd));
        chk("select_cycle", 32'(cyc), 32'(t.acc + 1));
      end
    end
    if (rsp_valid_a === 1'b1 || rsp_valid_b === 1'b1) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_rsp", 32'({rsp_valid_a, rsp_valid_b}), 32'(0));
      end else begin
        t = rsp_q.pop_front();
        chk("rsp_valid_a", 32'(rsp_valid_a), 32'(!t.b));
        chk("rsp_valid_b", 32'(rsp_valid_b), 32'(t.b));
        chk("rsp_data", 32'(rsp_data), 32'(t.rd));
        chk("rsp_cycle", 32'(cyc), 32'(t.acc + 2));
        $display("cyc %0d rsp %s adr=%0d data=%02h", cyc, t.b ? "B" : "A", t.adr, rsp_data);
      end
    end
  end

  task automatic req(input int w, input bit op, input logic [2:0] adr, input logic [7:0] wd);
    pend[w]  = 1'b1;
    p_op[w]  = op;
    p_adr[w] = adr;
    p_wd[w]  = wd;
  endtask

  // One clock cycle: drive, predict the grant, check ready/busy, then update the model.
  task automatic step(input bit r, input bit zchk);
    int   win;
    txn_t t;
    rst     = r;
    a_req   = pend[0]; a_op = p_op[0]; a_adr = p_adr[0]; a_wdata = p_wd[0];
    b_req   = pend[1]; b_op = p_op[1]; b_adr = p_adr[1]; b_wdata = p_wd[1];
    @(negedge clk);
    if (zchk) begin
      chk("zero_mem_select", 32'(mem_select), 32'(0));
      chk("zero_mem_op", 32'(mem_op), 32'(0));
      chk("zero_mem_adr", 32'(mem_adr), 32'(0));
      chk("zero_mem_wdata", 32'(mem_wdata), 32'(0));
      chk("zero_rsp_data", 32'(rsp_data), 32'(0));
      chk("zero_rsp_valid", 32'({rsp_valid_a, rsp_valid_b}), 32'(0));
    end
    chk("busy", 32'(busy), 32'(cyc < free));
    win = -1;
    if (!r && cyc >= free && (pend[0] || pend[1])) begin
      if (pend[0] && pend[1]) win = (RR && rr_b) ? 1 : 0;
      else win = pend[1] ? 1 : 0;
    end
    chk("a_ready", 32'(a_ready), 32'(win == 0));
    chk("b_ready", 32'(b_ready), 32'(win == 1));
    if (win >= 0) begin
      t.b   = (win == 1);
      t.op  = p_op[win];
      t.adr = p_adr[win];
      t.wd  = p_wd[win];
      t.rd  = mdl_mem[t.adr];
      t.acc = cyc;
      if (t.op) mdl_mem[t.adr] = t.wd;
      else rsp_q.push_back(t);
      acc_q.push_back(t);
      free = cyc + (t.op ? 2 : 3);
      rr_b = (win == 0);
      if (!auto_re[win]) pend[win] = 1'b0;
      $display("cyc %0d grant %s %s adr=%0d wdata=%02h", cyc, t.b ? "B" : "A",
               t.op ? "WR" : "RD", t.adr, t.wd);
    end
    if (r) free = cyc + 1;
    @(posedge clk);
    if (r) begin
      rsp_q.delete();
      acc_q.delete();
      rr_b = 1'b0;
      for (int i = 0; i < 8; i++) mdl_mem[i] = 8'(i * 17);
    end
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && (pend[0] || pend[1] || cyc < free); k++) step(1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mdl_mem[i] = 8'(i * 17);
    pend = '{1'b0, 1'b0};
    auto_re = '{1'b0, 1'b0};
    p_op = '{1'b0, 1'b0};
    p_adr = '{3'd0, 3'd0};
    p_wd = '{8'd0, 8'd0};
    repeat (2) @(posedge clk);
    #1;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);

    // A write then A read of the same location
    req(0, 1'b1, 3'd5, 8'hA5);
    wait_idle();
    req(0, 1'b0, 3'd5, 8'h00);
    wait_idle();

    // Both requesters reading continuously
    auto_re[0] = 1'b1; auto_re[1] = 1'b1;
    req(0, 1'b0, 3'd1, 8'h00);
    req(1, 1'b0, 3'd2, 8'h00);
    repeat (12) step(1'b0, 1'b0);
    auto_re[0] = 1'b0; auto_re[1] = 1'b0;
    wait_idle();

    // B write arrives while A read is in flight
    req(0, 1'b0, 3'd5, 8'h00);
    step(1'b0, 1'b0);
    req(1, 1'b1, 3'd6, 8'h3C);
    wait_idle();

    // Reset during the ACCESS cycle of an A read, then a fresh read
    req(0, 1'b0, 3'd3, 8'h00);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    req(0, 1'b0, 3'd3, 8'h00);
    wait_idle();

    // Fill every location via A, read all back via B
    for (int i = 0; i < 8; i++) begin
      req(0, 1'b1, 3'(i), 8'(i));
      wait_idle();
    end
    for (int i = 0; i < 8; i++) begin
      req(1, 1'b0, 3'(i), 8'h00);
      wait_idle();
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int w = 0; w < 2; w++) begin
        if (!pend[w] && $urandom_range(2) == 0)
          req(w, 1'($urandom_range(1)), 3'($urandom_range(7)), 8'($urandom_range(255)));
      end
      step(1'b0, 1'b0);
    end
    wait_idle();
    repeat (3) step(1'b0, 1'b0);

    chk("acc_q_drained", 32'(acc_q.size()), 32'(0));
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Sequences all accesses to the 8x8 memory array (3-bit address, 8-bit data, op/select control).
- Arbitrates between two requesters, A and B, using a valid/ready handshake.
- Drives the array control pins for exactly one access at a time, captures read data and returns a response pulse to the owning requester.
- Sits between the system bus logic and the memory module; it is the only driver of the array's op/select/address/input pins.

Parameters:
- ADDR_W, 3, address width; array depth = 2^ADDR_W.
- DATA_W, 8, data word width.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  requester A has a valid request.
- a_op  in  1  A operation: 1 = write, 0 = read.
- a_adr  in  ADDR_W  A address.
- a_wdata  in  DATA_W  A write data.
- a_ready  out  1  A request accepted this cycle.
- b_req, b_op, b_adr, b_wdata, b_ready  -- same as A, for requester B.
- rsp_valid_a  out  1  one-cycle pulse: A's read data valid on rsp_data.
- rsp_valid_b  out  1  one-cycle pulse: B's read data valid on rsp_data.
- rsp_data  out  DATA_W  registered read data, shared by both requesters.
- mem_adr  out  ADDR_W  to array address select.
- mem_op  out  1  to array op pin: 1 = write, 0 = read.
- mem_select  out  1  to array select; high for exactly one cycle per access.
- mem_wdata  out  DATA_W  to array data inputs.
- mem_rdata  in  DATA_W  from array outputs; valid in the cycle mem_select is high.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst = 1 at a clk edge): FSM -> IDLE; all outputs 0; owner register = A; RR pointer -> A preferred.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request pending: stay in IDLE.
  - At least one request: choose a winner. Only one requesting -> that one. Both requesting -> RR pointer side.
  - Pulse winner's ready for 1 cycle, combinationally in the same cycle as its req. Loser's ready stays 0.
  - Latch op/adr/wdata and owner. Next state ACCESS.
  - Flip RR pointer to the non-winner.
- ACCESS:
  - mem_select = 1 with mem_op/mem_adr/mem_wdata from the latch.
  - Write: array writes on this cycle; next state IDLE.
  - Read: register mem_rdata into rsp_data at the clk edge; next state RESP.
- RESP:
  - Pulse rsp_valid_<owner> for 1 cycle; rsp_data holds the value.
  - Next state IDLE.
- Latency:
  - Write occupies 2 cycles (accept + access).
  - Read occupies 3 cycles: response pulse 2 cycles after the ready pulse.
- Throughput: max one access per 2 cycles (write) or 3 cycles (read). No new accept while busy; ready = 0 outside IDLE.
- Requests are level-held. A requester keeps req and its fields stable until it sees ready; changes before ready are legal and simply sampled later.
- mem_adr/mem_op/mem_wdata hold their last latched values outside ACCESS. mem_select = 0 outside ACCESS.
- rsp_data holds its last read value until the next read completes; never cleared except by reset.
- Reset mid-operation: access abandoned. If asserted during ACCESS, mem_select drops on the reset cycle's next edge; no rsp_valid is issued. Requester must re-request.
- Same-requester back-to-back: allowed. Its next req can be accepted in the IDLE cycle immediately after completion.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: both-request tie goes to the RR pointer side; pointer flips after every grant, as described above.
- Undefined: fixed priority, A always wins ties. RR pointer logic is not generated; B may starve under continuous A traffic.

Test Plan:
- Reset then A write adr=5 data=0xA5:
  - a_ready pulses in cycle 0.
  - Cycle 1: mem_select=1, mem_op=1, mem_adr=5, mem_wdata=0xA5.
  - Cycle 2: busy=0.
- A read adr=5 with array model holding 0xA5: rsp_valid_a pulses 2 cycles after a_ready with rsp_data=0xA5; rsp_valid_b stays 0.
- A and B request continuously (reads, adr 1 and 2):
  - With macro defined: grants alternate A, B, A, B.
  - Without macro: only A granted over 4 accesses.
- B write arrives while A's read is in ACCESS: b_ready=0 until IDLE; B accepted in the first IDLE cycle; A's response unaffected.
- rst asserted during ACCESS of an A read: no rsp_valid_a; all outputs 0 next cycle; a fresh A read afterwards completes normally.
- Write 0x00..0x07 to adr 0..7, then read all 8 back via B: each rsp_data matches; every access shows mem_select high for exactly 1 cycle.
